// File: rtl/control_unit_pkg.sv
// Shared opcode/funct/ALUOp constants and the packed control word for the
// MIPS main control unit and its combinational decoder.
package control_unit_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_NANDI  = 6'b010000;
  localparam logic [5:0] OP_BLEZAL = 6'b100100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JALPC  = 6'b011111;
  localparam logic [5:0] OP_BALN   = 6'b011011;

  localparam logic [5:0] FN_JMXOR  = 6'b100011;
  localparam logic [5:0] FN_BRV    = 6'b010100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_NAND  = 3'b011;

  // Field order is the order the outputs appear on the top-level port list.
  typedef struct packed {
    logic       regdest;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [2:0] aluop;
    logic       jump;
    logic       brv;
    logic       jmxor;
    logic       nandi;
    logic       blezal;
    logic       jalpc;
    logic       baln;
  } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode/funct to control-word decoder.
module control_decode
  import control_unit_pkg::*;
(
  input  logic [5:0] in,
  input  logic [5:0] funct,
  output ctrl_word_t cw
);

  // Decode opcode (and funct for R-type); unknown opcodes leave everything 0.
  always_comb begin
    cw = '0;
    case (in)
      OP_RTYPE: begin
        cw.aluop = ALU_FUNCT;
        case (funct)
          FN_JMXOR: begin
            cw.jmxor    = 1'b1;
            cw.regwrite = 1'b1;
            cw.memread  = 1'b1;
          end
          FN_BRV: cw.brv = 1'b1;
          default: begin
            cw.regdest  = 1'b1;
            cw.regwrite = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        cw.alusrc   = 1'b1;
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
        cw.memread  = 1'b1;
        cw.aluop    = ALU_ADD;
      end
      OP_SW: begin
        cw.alusrc   = 1'b1;
        cw.memwrite = 1'b1;
        cw.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        cw.branch = 1'b1;
        cw.aluop  = ALU_SUB;
      end
      OP_NANDI: begin
        cw.nandi    = 1'b1;
        cw.alusrc   = 1'b1;
        cw.regwrite = 1'b1;
        cw.aluop    = ALU_NAND;
      end
      OP_BLEZAL: begin
        cw.blezal   = 1'b1;
        cw.regwrite = 1'b1;
        cw.aluop    = ALU_SUB;
      end
      OP_J: cw.jump = 1'b1;
      OP_JALPC: begin
        cw.jalpc    = 1'b1;
        cw.regwrite = 1'b1;
      end
      OP_BALN: begin
        cw.baln     = 1'b1;
        cw.regwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main control unit: decoder followed by a synchronously reset output
// register, giving one cycle of latency from in/funct to the strobes.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in,
  input  logic [5:0] funct,
  output logic       regdest,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       branch,
  output logic       aluop2,
  output logic       aluop1,
  output logic       aluop0,
  output logic       jump,
  output logic       brv,
  output logic       jmxor,
  output logic       nandi,
  output logic       blezal,
  output logic       jalpc,
  output logic       baln
);

  ctrl_word_t cw_next;
  ctrl_word_t cw_q;

  control_decode u_decode (
    .in    (in),
    .funct (funct),
    .cw    (cw_next)
  );

  // Register the decoded word; reset wins over any concurrent opcode.
  always_ff @(posedge clk) begin
    if (rst) cw_q <= '0;
    else     cw_q <= cw_next;
  end

  assign regdest  = cw_q.regdest;
  assign alusrc   = cw_q.alusrc;
  assign memtoreg = cw_q.memtoreg;
  assign regwrite = cw_q.regwrite;
  assign memread  = cw_q.memread;
  assign memwrite = cw_q.memwrite;
  assign branch   = cw_q.branch;
  assign aluop2   = cw_q.aluop[2];
  assign aluop1   = cw_q.aluop[1];
  assign aluop0   = cw_q.aluop[0];
  assign jump     = cw_q.jump;
  assign brv      = cw_q.brv;
  assign jmxor    = cw_q.jmxor;
  assign nandi    = cw_q.nandi;
  assign blezal   = cw_q.blezal;
  assign jalpc    = cw_q.jalpc;
  assign baln     = cw_q.baln;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of vectors plus hand-written
// reset/latency sequences, checked through an expected-value queue.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] in_op;
  logic [5:0] funct;
  logic regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch;
  logic aluop2, aluop1, aluop0;
  logic jump, brv, jmxor, nandi, blezal, jalpc, baln;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-output layout: datapath[6:0] _ aluop[2:0] _ flags[6:0]
  // datapath: regdest alusrc memtoreg regwrite memread memwrite branch
  // flags:    jump brv jmxor nandi blezal jalpc baln
  localparam logic [16:0] E_ZERO   = 17'b0000000_000_0000000;
  localparam logic [16:0] E_LW     = 17'b0111100_000_0000000;
  localparam logic [16:0] E_RTYPE  = 17'b1001000_010_0000000;
  localparam logic [16:0] E_JMXOR  = 17'b0001100_010_0010000;
  localparam logic [16:0] E_BRV    = 17'b0000000_010_0100000;
  localparam logic [16:0] E_SW     = 17'b0100010_000_0000000;
  localparam logic [16:0] E_BEQ    = 17'b0000001_001_0000000;
  localparam logic [16:0] E_NANDI  = 17'b0101000_011_0001000;
  localparam logic [16:0] E_BLEZAL = 17'b0001000_001_0000100;
  localparam logic [16:0] E_J      = 17'b0000000_000_1000000;
  localparam logic [16:0] E_JALPC  = 17'b0001000_000_0000010;
  localparam logic [16:0] E_BALN   = 17'b0001000_000_0000001;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [16:0] sb_q[$];
  string       sb_name[$];

  control_unit dut (
    .clk(clk), .rst(rst), .in(in_op), .funct(funct),
    .regdest(regdest), .alusrc(alusrc), .memtoreg(memtoreg),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .branch(branch), .aluop2(aluop2), .aluop1(aluop1), .aluop0(aluop0),
    .jump(jump), .brv(brv), .jmxor(jmxor), .nandi(nandi),
    .blezal(blezal), .jalpc(jalpc), .baln(baln)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] outs();
    return {regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch,
            aluop2, aluop1, aluop0,
            jump, brv, jmxor, nandi, blezal, jalpc, baln};
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    logic [6:0]  flags;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
    flags = act[6:0];
    n_checks++;
    if ($countones(flags) > 1) begin
      n_fail++;
      $display("FAIL %s_onehot: flags %b required at most one set", name, flags);
    end
  endtask

  // Drive one vector before an edge, queue its expectation, check after edge.
  task automatic apply(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic [16:0] exp, input string name);
    logic [16:0] e;
    string nm;
    @(negedge clk);
    rst = r; in_op = op; funct = fn;
    sb_q.push_back(exp);
    sb_name.push_back(name);
    @(posedge clk);
    #1;
    e  = sb_q.pop_front();
    nm = sb_name.pop_front();
    check(nm, e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_op = 6'b100011; funct = 6'b000000;

    vecs.push_back('{1'b1, 6'b100011, 6'b000000, E_ZERO,   "rst_lw_1"});
    vecs.push_back('{1'b1, 6'b100011, 6'b000000, E_ZERO,   "rst_lw_2"});
    vecs.push_back('{1'b0, 6'b100011, 6'b000000, E_LW,     "lw_after_rst"});
    vecs.push_back('{1'b0, 6'b000000, 6'b100100, E_RTYPE,  "rtype"});
    vecs.push_back('{1'b0, 6'b000000, 6'b100011, E_JMXOR,  "jmxor"});
    vecs.push_back('{1'b0, 6'b000000, 6'b010100, E_BRV,    "brv"});
    vecs.push_back('{1'b0, 6'b101011, 6'b000000, E_SW,     "sw"});
    vecs.push_back('{1'b0, 6'b000100, 6'b000000, E_BEQ,    "beq"});
    vecs.push_back('{1'b0, 6'b010000, 6'b000000, E_NANDI,  "nandi"});
    vecs.push_back('{1'b0, 6'b100100, 6'b000000, E_BLEZAL, "blezal"});
    vecs.push_back('{1'b0, 6'b000010, 6'b000000, E_J,      "j"});
    vecs.push_back('{1'b0, 6'b011111, 6'b000000, E_JALPC,  "jalpc"});
    vecs.push_back('{1'b0, 6'b011011, 6'b000000, E_BALN,   "baln"});
    vecs.push_back('{1'b0, 6'b111111, 6'b000000, E_ZERO,   "illegal_op"});
    vecs.push_back('{1'b0, 6'b100011, 6'b100011, E_LW,     "lw_fn_jmxor"});
    vecs.push_back('{1'b0, 6'b100011, 6'b010100, E_LW,     "lw_fn_brv"});
    vecs.push_back('{1'b0, 6'b100011, 6'b111111, E_LW,     "lw_fn_ones"});
    vecs.push_back('{1'b0, 6'b000000, 6'b000000, E_RTYPE,  "rtype_fn0"});
    vecs.push_back('{1'b0, 6'b000001, 6'b100011, E_ZERO,   "op1_fn_jmxor"});

    foreach (vecs[i])
      apply(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].exp, vecs[i].name);

    // Mid-cycle input change (incl. a glitch) must not reach the outputs
    // until the next rising edge.
    apply(1'b0, 6'b100011, 6'b000000, E_LW, "lw_pre_mid");
    in_op = 6'b101011;
    #1 in_op = 6'b111111;
    #1 in_op = 6'b101011;
    #1 check("held_mid_cycle", E_LW);
    @(posedge clk);
    #1 check("sw_next_edge", E_SW);

    // funct toggling during lw between edges has no effect.
    apply(1'b0, 6'b100011, 6'b000000, E_LW, "lw_pre_toggle");
    funct = 6'b100011;
    #1 funct = 6'b010100;
    @(posedge clk);
    #1 check("lw_funct_toggle", E_LW);

    // Reset asserted during a jalpc cycle clears on that edge, then the
    // first edge after release loads the current decode.
    apply(1'b0, 6'b011111, 6'b000000, E_JALPC, "jalpc_pre_rst");
    apply(1'b1, 6'b011111, 6'b000000, E_ZERO,  "rst_over_jalpc");
    apply(1'b0, 6'b011111, 6'b000000, E_JALPC, "jalpc_post_rst");

    // Random sweep of unused opcodes with random funct: all zero.
    for (int k = 0; k < 8; k++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 63));
      if (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b010000,
                     6'b100100, 6'b000010, 6'b011111, 6'b011011})
        op = 6'b110000;
      apply(1'b0, op, 6'($urandom_range(0, 63)), E_ZERO, "unused_op");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
